vending_txn_controller: RTL and testbench

VENDING_TXN_CONTROLLER -- requirements
Module: vending_txn_controller

---
 rtl/vending_txn_controller_pkg.sv | 38 +++
 rtl/vending_txn_controller_if.sv | 28 ++
 rtl/vending_change_selector.sv | 25 ++
 rtl/vending_txn_controller.sv | 123 ++++++++++++
 tb/tb_vending_txn_controller.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/vending_txn_controller_pkg.sv
// Shared definitions for the vending transaction controller: coin and item
// tables, FSM state encoding and small table-lookup helpers.
package vending_machine_def;

  localparam int kNumCoins = 3;
  localparam int kNumItems = 4;

  localparam logic [31:0] kCoinValue [kNumCoins] = '{32'd100, 32'd500, 32'd1000};
  localparam logic [31:0] kItemPrice [kNumItems] = '{32'd400, 32'd500, 32'd1000, 32'd2000};

  typedef enum logic [1:0] {
    IDLE,
    CREDIT,
    VEND,
    CHANGE
  } state_t;

  // Sum of the table entries whose bit is set; for a one-hot input this is
  // simply the value of the selected coin.
  function automatic logic [31:0] coin_value(input logic [kNumCoins-1:0] coin);
    logic [31:0] sum;
    sum = '0;
    for (int i = 0; i < kNumCoins; i++) begin
      if (coin[i]) sum = sum + kCoinValue[i];
    end
    return sum;
  endfunction

  function automatic logic [31:0] item_price(input logic [kNumItems-1:0] item);
    logic [31:0] sum;
    sum = '0;
    for (int i = 0; i < kNumItems; i++) begin
      if (item[i]) sum = sum + kItemPrice[i];
    end
    return sum;
  endfunction

endpackage

// File: rtl/vending_txn_controller_if.sv
// Customer, hopper and status signals of the vending controller; the
// master side drives coins/selects/acks, the slave side is the controller.
interface vending_txn_controller_if;
  import vending_machine_def::*;

  logic [kNumCoins-1:0] i_input_coin;
  logic [kNumItems-1:0] i_select_item;
  logic                 i_trigger_return;
  logic                 i_coin_ack;
  logic [kNumItems-1:0] o_available_item;
  logic [kNumItems-1:0] o_output_item;
  logic [kNumCoins-1:0] o_return_coin;
  logic                 o_coin_reject;
  logic [31:0]          o_balance;
  logic                 o_busy;

  modport master (
    output i_input_coin, i_select_item, i_trigger_return, i_coin_ack,
    input  o_available_item, o_output_item, o_return_coin, o_coin_reject,
           o_balance, o_busy
  );

  modport slave (
    input  i_input_coin, i_select_item, i_trigger_return, i_coin_ack,
    output o_available_item, o_output_item, o_return_coin, o_coin_reject,
           o_balance, o_busy
  );
endinterface

// File: rtl/vending_change_selector.sv
// Greedy change selection: picks the largest coin not exceeding the balance
// and reports it one-hot together with its value.
module vending_change_selector
  import vending_machine_def::*;
(
  input  logic [31:0]          balance,
  output logic [kNumCoins-1:0] coin,
  output logic [31:0]          value
);

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
    coin  = '0;
    value = '0;
    for (int i = 0; i < kNumCoins; i++) begin
      // Coin table is ascending, so the last match is the largest fitting coin.
      if (balance >= kCoinValue[i]) begin
        coin     = '0;
        coin[i]  = 1'b1;
        value    = kCoinValue[i];
      end
    end
  end

endmodule

// File: rtl/vending_txn_controller.sv
// Vending transaction controller: credits coins, vends affordable items,
// and returns change greedily after a return request or idle timeout.
module vending_txn_controller
  import vending_machine_def::*;
#(
  parameter int kWaitTime   = 10,
  parameter int kMaxBalance = 10000
) (
  input logic                  clk,
  input logic                  reset,
  vending_txn_controller_if.slave bus
);

  state_t               state;
  logic [31:0]          balance;
  logic [31:0]          timer;
  logic [kNumItems-1:0] vend_item;
  logic                 coin_reject;

  logic [31:0]          coin_val;
  logic [31:0]          sel_price;
  logic                 coin_ok;
  logic                 sel_ok;
  logic                 coin_seen;
  logic [kNumCoins-1:0] change_coin;
  logic [31:0]          change_value;

  vending_change_selector u_change_selector (
    .balance (balance),
    .coin    (change_coin),
    .value   (change_value)
  );

  assign coin_val  = coin_value(bus.i_input_coin);
  assign sel_price = item_price(bus.i_select_item);
  assign coin_seen = |bus.i_input_coin;
  // Sum in 33 bits so the ceiling compare can never wrap.
  assign coin_ok   = $onehot(bus.i_input_coin) &&
                     (({1'b0, balance} + {1'b0, coin_val}) <= 33'(kMaxBalance));
  assign sel_ok    = $onehot(bus.i_select_item) && (balance >= sel_price);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state       <= IDLE;
      balance     <= '0;
      timer       <= '0;
      vend_item   <= '0;
      coin_reject <= 1'b0;
    end else begin
      vend_item   <= '0;
      coin_reject <= 1'b0;
      unique case (state)
        IDLE, CREDIT: begin
          if (state == CREDIT && bus.i_trigger_return) begin
            state <= CHANGE;
            timer <= '0;
          end else if (coin_seen) begin
            // Any coin activity outranks a select in the same cycle.
            if (coin_ok) begin
              balance <= balance + coin_val;
              state   <= CREDIT;
              timer   <= 32'(kWaitTime);
            end else begin
              coin_reject <= 1'b1;
              if (state == CREDIT) begin
                if (timer <= 32'd1) begin
                  state <= CHANGE;
                  timer <= '0;
                end else begin
                  timer <= timer - 32'd1;
                end
              end
            end
          end else if (state == CREDIT && sel_ok) begin
            balance   <= balance - sel_price;
            vend_item <= bus.i_select_item;
            state     <= VEND;
          end else if (state == CREDIT) begin
            if (timer <= 32'd1) begin
              state <= CHANGE;
              timer <= '0;
            end else begin
              timer <= timer - 32'd1;
            end
          end
        end
        VEND: begin
          coin_reject <= coin_seen;
          if (balance != '0) begin
            state <= CREDIT;
            timer <= 32'(kWaitTime);
          end else begin
            state <= IDLE;
            timer <= '0;
          end
        end
        CHANGE: begin
          coin_reject <= coin_seen;
          if (bus.i_coin_ack) begin
            balance <= balance - change_value;
            if (balance == change_value) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.o_available_item = '0;
    for (int i = 0; i < kNumItems; i++) begin
      bus.o_available_item[i] = (state == CREDIT) && (balance >= kItemPrice[i]);
    end
  end

  assign bus.o_return_coin = (state == CHANGE) ? change_coin : '0;
  assign bus.o_output_item = vend_item;
  assign bus.o_coin_reject = coin_reject;
  assign bus.o_balance     = balance;
  assign bus.o_busy        = (state == VEND) || (state == CHANGE);

endmodule

// File: tb/tb_vending_txn_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// every cycle against an integer-arithmetic model of the vending rules.
module tb_vending_txn_controller;

  localparam int kWait = 10;
  localparam int kMax  = 10000;

  localparam int kCoinVal  [3] = '{100, 500, 1000};
  localparam int kItemCost [4] = '{400, 500, 1000, 2000};

  // Model phases: what the customer would observe, kept as plain integers.
  localparam int P_IDLE = 0, P_CREDIT = 1, P_VEND = 2, P_CHANGE = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  vending_txn_controller_if bus ();

  vending_txn_controller #(.kWaitTime(kWait), .kMaxBalance(kMax)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int         m_bal   = 0;
  int         m_phase = P_IDLE;
  int         m_left  = 0;
  logic [3:0] m_vend  = '0;
  logic       m_rej   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int greedy_index(input int b);
    int idx;
    idx = -1;
    for (int i = 0; i < 3; i++) if (b >= kCoinVal[i]) idx = i;
    return idx;
  endfunction

  function automatic int value_of(input logic [2:0] c);
    int v;
    v = 0;
    for (int i = 0; i < 3; i++) if (c[i]) v += kCoinVal[i];
    return v;
  endfunction

  function automatic int cost_of(input logic [3:0] s);
    int v;
    v = 0;
    for (int i = 0; i < 4; i++) if (s[i]) v += kItemCost[i];
    return v;
  endfunction

  task automatic idle_tick();
    m_left--;
    if (m_left == 0) m_phase = P_CHANGE;
  endtask

  task automatic model_step(input logic [2:0] coin, input logic [3:0] sel,
                            input logic trig, input logic ack, input logic rst);
    m_vend = '0;
    m_rej  = 1'b0;
    if (rst) begin
      m_phase = P_IDLE;
      m_bal   = 0;
      m_left  = 0;
    end else if (m_phase == P_IDLE || m_phase == P_CREDIT) begin
      if (m_phase == P_CREDIT && trig) begin
        m_phase = P_CHANGE;
      end else if (coin != 0) begin
        if ($countones(coin) == 1 && m_bal + value_of(coin) <= kMax) begin
          m_bal  += value_of(coin);
          m_phase = P_CREDIT;
          m_left  = kWait;
        end else begin
          m_rej = 1'b1;
          if (m_phase == P_CREDIT) idle_tick();
        end
      end else if (m_phase == P_CREDIT && $countones(sel) == 1 && m_bal >= cost_of(sel)) begin
        m_bal  -= cost_of(sel);
        m_vend  = sel;
        m_phase = P_VEND;
      end else if (m_phase == P_CREDIT) begin
        idle_tick();
      end
    end else if (m_phase == P_VEND) begin
      m_rej   = (coin != 0);
      m_phase = (m_bal > 0) ? P_CREDIT : P_IDLE;
      m_left  = kWait;
    end else begin
      m_rej = (coin != 0);
      if (ack) begin
        m_bal -= kCoinVal[greedy_index(m_bal)];
        if (m_bal == 0) m_phase = P_IDLE;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0] exp_avail;
    logic [2:0] exp_ret;
    exp_avail = '0;
    exp_ret   = '0;
    for (int i = 0; i < 4; i++) exp_avail[i] = (m_phase == P_CREDIT) && (m_bal >= kItemCost[i]);
    if (m_phase == P_CHANGE && greedy_index(m_bal) >= 0) exp_ret[greedy_index(m_bal)] = 1'b1;
    check({tag, "_balance"}, bus.o_balance, 32'(m_bal));
    check({tag, "_avail"},   32'(bus.o_available_item), 32'(exp_avail));
    check({tag, "_vend"},    32'(bus.o_output_item), 32'(m_vend));
    check({tag, "_return"},  32'(bus.o_return_coin), 32'(exp_ret));
    check({tag, "_reject"},  32'(bus.o_coin_reject), 32'(m_rej));
    check({tag, "_busy"},    32'(bus.o_busy),
          32'(m_phase == P_VEND || m_phase == P_CHANGE));
  endtask

  task automatic cycle(input logic [2:0] coin, input logic [3:0] sel, input logic trig,
                       input logic ack, input logic rst, input string tag);
    @(negedge clk);
    bus.i_input_coin     = coin;
    bus.i_select_item    = sel;
    bus.i_trigger_return = trig;
    bus.i_coin_ack       = ack;
    reset                = rst;
    model_step(coin, sel, trig, ack, rst);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    bus.i_input_coin     = '0;
    bus.i_select_item    = '0;
    bus.i_trigger_return = 1'b0;
    bus.i_coin_ack       = 1'b0;

    cycle(3'b000, 4'b0000, 1'b0, 1'b1, 1'b1, "reset");
    check("reset_outputs_zero", 32'({bus.o_available_item, bus.o_output_item,
          bus.o_return_coin, bus.o_coin_reject, bus.o_busy}), 32'd0);

    // Coins 1000 then 500.
    cycle(3'b100, 4'b0000, 1'b0, 1'b0, 1'b0, "coin1000");
    cycle(3'b010, 4'b0000, 1'b0, 1'b0, 1'b0, "coin500");
    check("credit_1500", bus.o_balance, 32'd1500);
    check("avail_0111", 32'(bus.o_available_item), 32'b0111);

    // Vend the 1000 item.
    cycle(3'b000, 4'b0100, 1'b0, 1'b0, 1'b0, "vend");
    check("vend_pulse", 32'(bus.o_output_item), 32'b0100);
    check("vend_balance", bus.o_balance, 32'd500);
    cycle(3'b000, 4'b0000, 1'b0, 1'b0, 1'b0, "post_vend");
    check("vend_one_cycle", 32'(bus.o_output_item), 32'd0);

    // Balance 600, return request, greedy change with held request.
    cycle(3'b001, 4'b0000, 1'b0, 1'b0, 1'b0, "coin100");
    cycle(3'b000, 4'b0000, 1'b1, 1'b0, 1'b0, "trigger");
    check("change_500_req", 32'(bus.o_return_coin), 32'b010);
    cycle(3'b000, 4'b0000, 1'b0, 1'b0, 1'b0, "hold1");
    cycle(3'b000, 4'b0000, 1'b0, 1'b0, 1'b0, "hold2");
    check("change_500_held", 32'(bus.o_return_coin), 32'b010);
    cycle(3'b000, 4'b0000, 1'b0, 1'b1, 1'b0, "ack500");
    check("change_100_req", 32'(bus.o_return_coin), 32'b001);
    cycle(3'b000, 4'b0000, 1'b0, 1'b1, 1'b0, "ack100");
    check("change_done", 32'(bus.o_return_coin), 32'd0);

    // Idle timeout from balance 100.
    cycle(3'b001, 4'b0000, 1'b0, 1'b0, 1'b0, "timeout_coin");
    for (int i = 0; i < kWait - 1; i++) cycle(3'b000, 4'b0000, 1'b0, 1'b0, 1'b0, "timeout_wait");
    check("timeout_not_yet", 32'(bus.o_busy), 32'd0);
    cycle(3'b000, 4'b0000, 1'b0, 1'b0, 1'b0, "timeout_fire");
    check("timeout_change", 32'(bus.o_return_coin), 32'b001);
    cycle(3'b000, 4'b0000, 1'b0, 1'b1, 1'b0, "timeout_ack");

    // Coin beats select in the same cycle; malformed coin is refused.
    for (int i = 0; i < 4; i++) cycle(3'b001, 4'b0000, 1'b0, 1'b0, 1'b0, "build400");
    cycle(3'b001, 4'b0001, 1'b0, 1'b0, 1'b0, "coin_vs_sel");
    check("coin_wins_bal", bus.o_balance, 32'd500);
    check("coin_wins_novend", 32'(bus.o_output_item), 32'd0);
    cycle(3'b011, 4'b0000, 1'b0, 1'b0, 1'b0, "bad_coin");
    check("bad_coin_reject", 32'(bus.o_coin_reject), 32'd1);
    cycle(3'b000, 4'b0000, 1'b1, 1'b0, 1'b0, "drain_trig");
    cycle(3'b000, 4'b0000, 1'b0, 1'b1, 1'b0, "drain_ack");

    // Balance ceiling, then reset with a 1000 request pending.
    for (int i = 0; i < 10; i++) cycle(3'b100, 4'b0000, 1'b0, 1'b0, 1'b0, "fill");
    check("ceiling_bal", bus.o_balance, 32'(kMax));
    cycle(3'b001, 4'b0000, 1'b0, 1'b0, 1'b0, "over_max");
    check("over_max_reject", 32'(bus.o_coin_reject), 32'd1);
    cycle(3'b000, 4'b0000, 1'b1, 1'b0, 1'b0, "max_trig");
    check("pending_1000", 32'(bus.o_return_coin), 32'b100);
    cycle(3'b000, 4'b0000, 1'b0, 1'b1, 1'b1, "reset_pending");
    check("reset_clears_req", 32'(bus.o_return_coin), 32'd0);
    cycle(3'b000, 4'b0000, 1'b0, 1'b1, 1'b0, "late_ack");
    check("late_ack_ignored", bus.o_balance, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] coin;
      logic [3:0] sel;
      int r;
      r = $urandom_range(0, 9);
      if (r < 6)      coin = '0;
      else if (r < 9) coin = 3'(1 << $urandom_range(0, 2));
      else            coin = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      if (r < 5)      sel = '0;
      else if (r < 9) sel = 4'(1 << $urandom_range(0, 3));
      else            sel = 4'($urandom_range(0, 15));
      cycle(coin, sel, ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 199) == 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
